// File: rtl/javk_busctl.sv
// ----------------------------------------------------------------------------
// javk_busctl -- round-robin memory-bus sequencer for the JAVK CPU.
//
// Shares the single 8-bit data / 16-bit address external bus between the
// internal requesters (0 = fetch, 1 = load/store, 2 = stack). Each transfer
// is a byte or a little-endian 16-bit word and is serialised into one or two
// byte bus cycles. Read data is returned with a single-cycle done pulse.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req           per-requester level request, held until done
//   req_addr      packed 16-bit start addresses, requester i at [16i+15:16i]
//   req_we        1 = write, 0 = read
//   req_wide      1 = 16-bit transfer, 0 = byte
//   req_wdata     packed 16-bit write data, low byte to the start address
//   gnt           one-hot owner of the bus (B0/B1)
//   done          one-hot single-cycle completion pulse (ACK)
//   rdata         read result, zero-extended for byte reads, held otherwise
//   mem_addr      external address bus
//   mem_rw        1 = write byte cycle, 0 = read / no cycle
//   mem_wdata     byte driven during write cycles
//   mem_rdata     byte from the bus, sampled at the end of a read byte cycle
// ----------------------------------------------------------------------------
module javk_busctl #(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_wide,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [15:0]          rdata,
    output logic [15:0]          mem_addr,
    output logic                 mem_rw,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_ACK} state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr, w_ptr_nxt;
    logic [PW-1:0]     r_win, w_win_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]   r_done, w_done_nxt;
    logic [15:0]       r_rdata, w_rdata_nxt;
    logic [15:0]       r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_rw, w_mem_rw_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [15:0]       r_addr, w_addr_nxt;
    logic [15:0]       r_wdata, w_wdata_nxt;
    logic              r_we, w_we_nxt;
    logic              r_wide, w_wide_nxt;
    logic [7:0]        r_rlo, w_rlo_nxt;

    // Round-robin pick
    logic              w_found;
    logic [PW-1:0]     w_pick;
    logic [NREQ-1:0]   w_sel_1hot;
    logic [15:0]       w_sel_addr;
    logic [15:0]       w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_wide;
    logic [PW-1:0]     w_ptr_inc;

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_rw    = r_mem_rw;
    assign mem_wdata = r_mem_wdata;

    // Two passes give "first set bit at ptr, ptr+1, ... mod NREQ": the first
    // pass covers indices at or above ptr, the second wraps to those below.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_sel_1hot  = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        w_sel_wide  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (PW'(i) >= r_ptr)) begin
                w_found       = 1'b1;
                w_pick        = PW'(i);
                w_sel_1hot    = '0;
                w_sel_1hot[i] = 1'b1;
                w_sel_addr    = req_addr[16*i +: 16];
                w_sel_wdata   = req_wdata[16*i +: 16];
                w_sel_we      = req_we[i];
                w_sel_wide    = req_wide[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                w_found       = 1'b1;
                w_pick        = PW'(i);
                w_sel_1hot    = '0;
                w_sel_1hot[i] = 1'b1;
                w_sel_addr    = req_addr[16*i +: 16];
                w_sel_wdata   = req_wdata[16*i +: 16];
                w_sel_we      = req_we[i];
                w_sel_wide    = req_wide[i];
            end
        end
    end

    assign w_ptr_inc = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

    // Next-state and next-output logic. Every output is registered, so each
    // branch prepares the values that will be visible in the following state.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_win_nxt       = r_win;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = '0;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_rw_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_we_nxt        = r_we;
        w_wide_nxt      = r_wide;
        w_rlo_nxt       = r_rlo;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nxt       = w_pick;
                    w_gnt_nxt       = w_sel_1hot;
                    w_addr_nxt      = w_sel_addr;
                    w_wdata_nxt     = w_sel_wdata;
                    w_we_nxt        = w_sel_we;
                    w_wide_nxt      = w_sel_wide;
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_rw_nxt    = w_sel_we;
                    w_mem_wdata_nxt = w_sel_wdata[7:0];
                    w_state_nxt     = S_B0;
                end
            end
            S_B0: begin
                if (r_wide) begin
                    // Low byte is parked so rdata stays stable until done.
                    if (!r_we) begin
                        w_rlo_nxt = mem_rdata;
                    end
                    w_mem_addr_nxt  = r_addr + 16'd1;
                    w_mem_rw_nxt    = r_we;
                    w_mem_wdata_nxt = r_wdata[15:8];
                    w_state_nxt     = S_B1;
                end else begin
                    if (!r_we) begin
                        w_rdata_nxt = {8'h00, mem_rdata};
                    end
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = S_ACK;
                end
            end
            S_B1: begin
                if (!r_we) begin
                    w_rdata_nxt = {mem_rdata, r_rlo};
                end
                w_done_nxt  = r_gnt;
                w_gnt_nxt   = '0;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_wdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_wide      <= 1'b0;
            r_rlo       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_win       <= w_win_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_rw    <= w_mem_rw_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_wide      <= w_wide_nxt;
            r_rlo       <= w_rlo_nxt;
        end
    end

endmodule
